// File: rtl/cola_vend_if.sv
// Coin/cancel inputs and dispenser/refund outputs of the two-slot cola vending controller.
interface cola_vend_if #(
  parameter int CREDIT_W = 3
);
  logic                pi_coin_a;
  logic                pi_coin_b;
  logic                pi_cancel_a;
  logic                pi_cancel_b;
  logic                po_cola;
  logic                po_sel;
  logic                po_busy;
  logic                po_refund_a;
  logic                po_refund_b;
  logic                po_reject_a;
  logic                po_reject_b;
  logic [CREDIT_W-1:0] po_credit_a;
  logic [CREDIT_W-1:0] po_credit_b;

  modport master (
    output pi_coin_a, pi_coin_b, pi_cancel_a, pi_cancel_b,
    input  po_cola, po_sel, po_busy, po_refund_a, po_refund_b,
    input  po_reject_a, po_reject_b, po_credit_a, po_credit_b
  );

  modport slave (
    input  pi_coin_a, pi_coin_b, pi_cancel_a, pi_cancel_b,
    output po_cola, po_sel, po_busy, po_refund_a, po_refund_b,
    output po_reject_a, po_reject_b, po_credit_a, po_credit_b
  );
endinterface

// File: rtl/cola_vend_ctrl.sv
// Two coin slots sharing one dispenser: per-slot credit/refund handling plus a
// round-robin arbiter that grants the dispenser for DISP_CYCLES cycles per vend.
module cola_vend_ctrl #(
  parameter int PRICE       = 3,
  parameter int DISP_CYCLES = 4,
  parameter int CREDIT_W    = 3
) (
  input logic         clk,
  input logic         rst,
  cola_vend_if.slave  bus
);

  localparam int                 CNT_W      = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_INIT   = CNT_W'(DISP_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_W-1:0] ONE_C      = CREDIT_W'(1);

  typedef enum logic {IDLE, VEND} state_t;

  state_t               state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 cola_q, cola_nxt;
  logic                 busy_q, busy_nxt;
  logic                 sel_q, sel_nxt;
  logic                 ptr_q, ptr_nxt;
  logic                 winner;

  logic [1:0]           coin, cancel;
  logic [1:0]           cancel_go, coin_acc, req, grant;
  logic [1:0]           refund_mode_q, refund_mode_nxt;
  logic [1:0]           refund_q, refund_nxt;
  logic [1:0]           reject_q, reject_nxt;
  logic [CREDIT_W-1:0]  credit_q   [2];
  logic [CREDIT_W-1:0]  credit_nxt [2];

  // Credit after an optional vend charge and an optional accepted coin; coin
  // acceptance already excludes a full counter and a grant implies credit >= PRICE.
  function automatic logic [CREDIT_W-1:0] credit_update(
    input logic [CREDIT_W-1:0] credit,
    input logic                charge,
    input logic                add_coin
  );
    logic [CREDIT_W-1:0] tmp;
    tmp = charge ? (credit - PRICE_C) : credit;
    return tmp + CREDIT_W'(add_coin);
  endfunction

  always_comb begin
    coin   = {bus.pi_coin_b, bus.pi_coin_a};
    cancel = {bus.pi_cancel_b, bus.pi_cancel_a};
    for (int i = 0; i < 2; i++) begin
      cancel_go[i] = !refund_mode_q[i] && cancel[i] && (credit_q[i] != '0);
      coin_acc[i]  = coin[i] && !refund_mode_q[i] && !cancel_go[i] &&
                     (credit_q[i] != CREDIT_MAX);
      req[i]       = !refund_mode_q[i] && (credit_q[i] >= PRICE_C) && !cancel[i];
    end
  end

  // Arbiter: ptr_q remembers the slot served last, so a tie goes to the other one.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    cola_nxt  = 1'b0;
    busy_nxt  = busy_q;
    sel_nxt   = sel_q;
    ptr_nxt   = ptr_q;
    winner    = 1'b0;
    grant     = 2'b00;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          winner        = (req == 2'b11) ? ~ptr_q : req[1];
          grant[winner] = 1'b1;
          state_nxt     = VEND;
          cnt_nxt       = CNT_INIT;
          cola_nxt      = 1'b1;
          busy_nxt      = 1'b1;
          sel_nxt       = winner;
          ptr_nxt       = winner;
        end
      end
      VEND: begin
        if (cnt_q == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A refund pays back one coin per cycle; the slot leaves REFUND on the cycle
  // that pays out the last coin.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      refund_mode_nxt[i] = refund_mode_q[i];
      refund_nxt[i]      = 1'b0;
      reject_nxt[i]      = coin[i] && !coin_acc[i];
      credit_nxt[i]      = credit_q[i];
      if (refund_mode_q[i] || cancel_go[i]) begin
        refund_nxt[i]      = 1'b1;
        credit_nxt[i]      = credit_q[i] - ONE_C;
        refund_mode_nxt[i] = (credit_q[i] != ONE_C);
      end else begin
        credit_nxt[i] = credit_update(credit_q[i], grant[i], coin_acc[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cola_q        <= 1'b0;
      busy_q        <= 1'b0;
      sel_q         <= 1'b0;
      ptr_q         <= 1'b1;
      refund_mode_q <= 2'b00;
      refund_q      <= 2'b00;
      reject_q      <= 2'b00;
      credit_q[0]   <= '0;
      credit_q[1]   <= '0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      cola_q        <= cola_nxt;
      busy_q        <= busy_nxt;
      sel_q         <= sel_nxt;
      ptr_q         <= ptr_nxt;
      refund_mode_q <= refund_mode_nxt;
      refund_q      <= refund_nxt;
      reject_q      <= reject_nxt;
      credit_q[0]   <= credit_nxt[0];
      credit_q[1]   <= credit_nxt[1];
    end
  end

  assign bus.po_cola     = cola_q;
  assign bus.po_sel      = sel_q;
  assign bus.po_busy     = busy_q;
  assign bus.po_refund_a = refund_q[0];
  assign bus.po_refund_b = refund_q[1];
  assign bus.po_reject_a = reject_q[0];
  assign bus.po_reject_b = reject_q[1];
  assign bus.po_credit_a = credit_q[0];
  assign bus.po_credit_b = credit_q[1];

endmodule

// File: tb/tb_cola_vend_ctrl.sv
// Directed bench for cola_vend_ctrl (PRICE=3, DISP_CYCLES=4, CREDIT_W=3) with
// hand-computed expectations sampled 1ns after each rising edge.
module tb_cola_vend_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cola_cnt;
  int   refund_cnt;

  cola_vend_if #(.CREDIT_W(3)) bus ();

  cola_vend_ctrl #(
    .PRICE       (3),
    .DISP_CYCLES (4),
    .CREDIT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ca, input logic cb, input logic xa, input logic xb);
    bus.pi_coin_a   = ca;
    bus.pi_coin_b   = cb;
    bus.pi_cancel_a = xa;
    bus.pi_cancel_b = xb;
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, bus.po_cola, bus.po_sel, bus.po_busy, bus.po_refund_a, bus.po_refund_b,
            bus.po_reject_a, bus.po_reject_b, bus.po_credit_a, bus.po_credit_b};
  endfunction

  task automatic do_reset();
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    set_in(0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_in(0, 0, 0, 0);

    // ---- reset then single vend on A
    do_reset();
    check("reset_outs", all_outs(), 0);
    set_in(1, 0, 0, 0);
    tick(); check("t1_credit1", bus.po_credit_a, 1);
    tick(); check("t1_credit2", bus.po_credit_a, 2);
    tick(); check("t1_credit3", bus.po_credit_a, 3);
    check("t1_no_cola_yet", bus.po_cola, 0);
    set_in(0, 0, 0, 0);
    tick();
    check("t1_cola", bus.po_cola, 1);
    check("t1_sel", bus.po_sel, 0);
    check("t1_credit_end", bus.po_credit_a, 0);
    cola_cnt = 1;
    for (int i = 0; i < 3; i++) begin
      check("t1_busy_hold", bus.po_busy, 1);
      tick();
      cola_cnt += bus.po_cola;
    end
    check("t1_busy_last", bus.po_busy, 1);
    tick();
    check("t1_busy_drop", bus.po_busy, 0);
    check("t1_cola_count", cola_cnt, 1);

    // ---- tie arbitration and alternation
    do_reset();
    set_in(1, 1, 0, 0);
    tick(); tick(); tick();
    check("t2_credit_a3", bus.po_credit_a, 3);
    check("t2_credit_b3", bus.po_credit_b, 3);
    set_in(0, 0, 0, 0);
    tick();
    check("t2_first_cola", bus.po_cola, 1);
    check("t2_first_sel_a", bus.po_sel, 0);
    check("t2_first_credit_a", bus.po_credit_a, 0);
    check("t2_b_waits", bus.po_credit_b, 3);
    set_in(1, 0, 0, 0);
    tick(); tick(); tick();
    check("t2_a_refill", bus.po_credit_a, 3);
    set_in(0, 0, 0, 0);
    tick();
    check("t2_idle_gap_busy", bus.po_busy, 0);
    check("t2_idle_gap_cola", bus.po_cola, 0);
    tick();
    check("t2_second_cola", bus.po_cola, 1);
    check("t2_second_sel_b", bus.po_sel, 1);
    check("t2_second_credit_b", bus.po_credit_b, 0);
    check("t2_a_still3", bus.po_credit_a, 3);
    set_in(0, 1, 0, 0);
    tick(); tick(); tick();
    set_in(0, 0, 0, 0);
    tick();
    check("t2_gap2_busy", bus.po_busy, 0);
    tick();
    check("t2_third_cola", bus.po_cola, 1);
    check("t2_third_sel_a", bus.po_sel, 0);
    check("t2_third_credit_a", bus.po_credit_a, 0);
    check("t2_third_credit_b", bus.po_credit_b, 3);
    idle_ticks(10);
    check("t2_drain_credit_b", bus.po_credit_b, 0);
    check("t2_drain_busy", bus.po_busy, 0);

    // ---- cancel/refund on A with coin rejected during refund
    do_reset();
    set_in(1, 0, 0, 0);
    tick(); tick();
    check("t3_credit2", bus.po_credit_a, 2);
    set_in(0, 0, 1, 0);
    tick();
    check("t3_refund1", bus.po_refund_a, 1);
    check("t3_credit1", bus.po_credit_a, 1);
    set_in(1, 0, 0, 0);
    tick();
    check("t3_refund2", bus.po_refund_a, 1);
    check("t3_credit0", bus.po_credit_a, 0);
    check("t3_reject_a", bus.po_reject_a, 1);
    set_in(0, 0, 0, 0);
    tick();
    check("t3_refund_end", bus.po_refund_a, 0);
    check("t3_reject_end", bus.po_reject_a, 0);
    check("t3_credit_stay0", bus.po_credit_a, 0);
    check("t3_no_cola", bus.po_cola, 0);
    set_in(0, 0, 1, 0);
    tick();
    check("t3_cancel_zero_ignored", bus.po_refund_a, 0);
    set_in(1, 0, 0, 0);
    tick();
    check("t3_normal_again", bus.po_credit_a, 1);

    // ---- saturation on B and vend with a coin on the grant edge
    do_reset();
    set_in(1, 1, 0, 0);
    tick(); tick(); tick();
    set_in(0, 1, 0, 0);
    tick();
    check("t4_a_vend_sel", bus.po_sel, 0);
    check("t4_b_credit4", bus.po_credit_b, 4);
    tick(); tick(); tick();
    check("t4_b_credit7", bus.po_credit_b, 7);
    check("t4_no_reject_yet", bus.po_reject_b, 0);
    tick();
    check("t4_reject_b", bus.po_reject_b, 1);
    check("t4_b_sat7", bus.po_credit_b, 7);
    set_in(0, 0, 0, 0);
    tick();
    check("t4_b_cola", bus.po_cola, 1);
    check("t4_b_sel", bus.po_sel, 1);
    check("t4_b_credit_after", bus.po_credit_b, 4);
    check("t4_reject_clear", bus.po_reject_b, 0);
    tick(); tick(); tick(); tick();
    set_in(0, 1, 0, 0);
    tick();
    check("t4_b_cola2", bus.po_cola, 1);
    check("t4_b_credit_coin", bus.po_credit_b, 2);
    idle_ticks(6);
    check("t4_end_busy", bus.po_busy, 0);

    // ---- cancel beats grant on A, B vended instead
    do_reset();
    set_in(1, 1, 0, 0);
    tick(); tick(); tick();
    set_in(0, 0, 1, 0);
    tick();
    check("t5_cola", bus.po_cola, 1);
    check("t5_sel_b", bus.po_sel, 1);
    check("t5_credit_b", bus.po_credit_b, 0);
    check("t5_credit_a2", bus.po_credit_a, 2);
    refund_cnt = bus.po_refund_a;
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      refund_cnt += bus.po_refund_a;
    end
    check("t5_refund_count", refund_cnt, 3);
    check("t5_credit_a0", bus.po_credit_a, 0);

    // ---- reset during VEND while A refunds
    do_reset();
    set_in(1, 1, 0, 0);
    tick(); tick(); tick();
    set_in(0, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0);
    tick();
    check("t6_busy_pre", bus.po_busy, 1);
    check("t6_refund_pre", bus.po_refund_a, 1);
    check("t6_credit_a_pre", bus.po_credit_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_reset_outs", all_outs(), 0);
    cola_cnt   = 0;
    refund_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cola_cnt   += bus.po_cola;
      refund_cnt += bus.po_refund_a + bus.po_refund_b;
    end
    check("t6_no_cola", cola_cnt, 0);
    check("t6_no_refund", refund_cnt, 0);
    set_in(1, 0, 0, 0);
    tick();
    check("t6_new_coin", bus.po_credit_a, 1);
    set_in(0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
